// File: rtl/gpio_port_regs.sv
// gpio_port_regs
//   Two CPU-writable GPIO output ports, two synchronized GPIO input ports with
//   per-port sticky change flags, a CPU readback mux and a level interrupt.
//
// Ports
//   clk       : single clock, all state updates on its rising edge
//   rst       : synchronous active-high reset
//   we1, we2  : write strobes for output ports 1 and 2 (from address decoder)
//   re        : CPU read strobe, qualifies read_sel for change-flag clearing
//   read_sel  : readback select 00=gpi1, 01=gpi2, 10=gpo1, 11=gpo2
//   wd        : CPU write data
//   gpi1/gpi2 : asynchronous external inputs
//   gpo1/gpo2 : registered output ports
//   rd        : CPU read data (combinational mux)
//   irq       : level interrupt, high while either change flag is set
module gpio_port_regs #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we1,
    input  logic             we2,
    input  logic             re,
    input  logic [1:0]       read_sel,
    input  logic [WIDTH-1:0] wd,
    input  logic [WIDTH-1:0] gpi1,
    input  logic [WIDTH-1:0] gpi2,
    output logic [WIDTH-1:0] gpo1,
    output logic [WIDTH-1:0] gpo2,
    output logic [WIDTH-1:0] rd,
    output logic             irq
);

    logic [WIDTH-1:0] r_gpo1;
    logic [WIDTH-1:0] r_gpo2;

    logic [WIDTH-1:0] r_gpi1_s1;
    logic [WIDTH-1:0] r_gpi1_s2;
    logic [WIDTH-1:0] r_gpi1_prev;
    logic [WIDTH-1:0] r_gpi2_s1;
    logic [WIDTH-1:0] r_gpi2_s2;
    logic [WIDTH-1:0] r_gpi2_prev;

    logic             r_chg1;
    logic             r_chg2;

    logic             w_det1;
    logic             w_det2;
    logic             w_clr1;
    logic             w_clr2;

    // Output port registers; both may load wd on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpo1 <= '0;
            r_gpo2 <= '0;
        end else begin
            if (we1) r_gpo1 <= wd;
            if (we2) r_gpo2 <= wd;
        end
    end

    // Stage 1/2: two-flop synchronizers; stage 3: previous-value registers
    // used only for change detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpi1_s1   <= '0;
            r_gpi1_s2   <= '0;
            r_gpi1_prev <= '0;
            r_gpi2_s1   <= '0;
            r_gpi2_s2   <= '0;
            r_gpi2_prev <= '0;
        end else begin
            r_gpi1_s1   <= gpi1;
            r_gpi1_s2   <= r_gpi1_s1;
            r_gpi1_prev <= r_gpi1_s2;
            r_gpi2_s1   <= gpi2;
            r_gpi2_s2   <= r_gpi2_s1;
            r_gpi2_prev <= r_gpi2_s2;
        end
    end

    assign w_det1 = (r_gpi1_s2 != r_gpi1_prev);
    assign w_det2 = (r_gpi2_s2 != r_gpi2_prev);
    assign w_clr1 = re && (read_sel == 2'b00);
    assign w_clr2 = re && (read_sel == 2'b01);

    // Sticky change flags: a fresh change on the clearing edge wins over the
    // clear so that no event is lost between the read and the flag drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chg1 <= 1'b0;
            r_chg2 <= 1'b0;
        end else begin
            if (w_det1)      r_chg1 <= 1'b1;
            else if (w_clr1) r_chg1 <= 1'b0;

            if (w_det2)      r_chg2 <= 1'b1;
            else if (w_clr2) r_chg2 <= 1'b0;
        end
    end

    always_comb begin
        rd = '0;
        case (read_sel)
            2'b00:   rd = r_gpi1_s2;
            2'b01:   rd = r_gpi2_s2;
            2'b10:   rd = r_gpo1;
            default: rd = r_gpo2;
        endcase
    end

    assign gpo1 = r_gpo1;
    assign gpo2 = r_gpo2;
    assign irq  = r_chg1 | r_chg2;

endmodule

// File: tb/tb_gpio_port_regs.sv
// tb_gpio_port_regs
//   Directed bench for gpio_port_regs: a vector table for single-edge write
//   and readback behaviour, plus hand-written sequences for synchronizer
//   latency, flag clear priority and reset behaviour.
module tb_gpio_port_regs;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             we1;
    logic             we2;
    logic             re;
    logic [1:0]       read_sel;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] gpi1;
    logic [WIDTH-1:0] gpi2;
    logic [WIDTH-1:0] gpo1;
    logic [WIDTH-1:0] gpo2;
    logic [WIDTH-1:0] rd;
    logic             irq;

    int pass_cnt;
    int total_cnt;

    gpio_port_regs #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .we1      (we1),
        .we2      (we2),
        .re       (re),
        .read_sel (read_sel),
        .wd       (wd),
        .gpi1     (gpi1),
        .gpi2     (gpi2),
        .gpo1     (gpo1),
        .gpo2     (gpo2),
        .rd       (rd),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             we1;
        logic             we2;
        logic [1:0]       read_sel;
        logic [WIDTH-1:0] wd;
        logic [WIDTH-1:0] exp_gpo1;
        logic [WIDTH-1:0] exp_gpo2;
        logic [WIDTH-1:0] exp_rd;
        logic             exp_irq;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic check_irq(input string name, input logic exp);
        check(name, {{(WIDTH-1){1'b0}}, irq}, {{(WIDTH-1){1'b0}}, exp});
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;

        vecs[0] = '{1'b1, 1'b0, 2'b10, 32'h0000_00A5, 32'h0000_00A5, 32'h0,         32'h0000_00A5, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 2'b11, 32'h1234_5678, 32'h0000_00A5, 32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'h0000_00A5, 32'h1234_5678, 32'h0000_00A5, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 2'b11, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 2'b00, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0,         1'b0};

        // Reset with write strobe asserted: the write must be ignored.
        rst = 1'b1; we1 = 1'b1; we2 = 1'b1; re = 1'b0; read_sel = 2'b10;
        wd = 32'h1111_1111; gpi1 = '0; gpi2 = '0;
        tick();
        tick();
        check("reset_gpo1", gpo1, 32'h0);
        check("reset_gpo2", gpo2, 32'h0);
        check("reset_rd", rd, 32'h0);
        check_irq("reset_irq", 1'b0);
        rst = 1'b0; we1 = 1'b0; we2 = 1'b0;

        for (int i = 0; i < 5; i++) begin
            we1 = vecs[i].we1; we2 = vecs[i].we2;
            read_sel = vecs[i].read_sel; wd = vecs[i].wd;
            tick();
            check($sformatf("vec%0d_gpo1", i), gpo1, vecs[i].exp_gpo1);
            check($sformatf("vec%0d_gpo2", i), gpo2, vecs[i].exp_gpo2);
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            check_irq($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
        end
        we1 = 1'b0; we2 = 1'b0;

        // Same-cycle readback returns the old value, new value after the edge.
        we1 = 1'b1; wd = 32'h0BAD_F00D; read_sel = 2'b10;
        #1;
        check("wr_same_cycle_rd", rd, 32'hDEAD_BEEF);
        tick();
        we1 = 1'b0;
        check("wr_after_edge_rd", rd, 32'h0BAD_F00D);

        // Synchronizer latency on port 2.
        gpi2 = 32'h0000_0F00; read_sel = 2'b01;
        #1;
        check("lat_before_k_rd", rd, 32'h0);
        tick();
        check("lat_k_rd", rd, 32'h0);
        check_irq("lat_k_irq", 1'b0);
        tick();
        check("lat_k1_rd", rd, 32'h0000_0F00);
        check_irq("lat_k1_irq", 1'b0);
        tick();
        check_irq("lat_k2_irq", 1'b1);
        re = 1'b1; read_sel = 2'b01;
        tick();
        re = 1'b0;
        check_irq("clr2_irq", 1'b0);

        // Set wins over clear on port 1.
        gpi1 = 32'h1;
        tick(); tick(); tick();
        check_irq("chg1_set_irq", 1'b1);
        gpi1 = 32'h3;
        tick(); tick();
        // Next edge sees s2=3 against prev=1 while the clear read is issued.
        re = 1'b1; read_sel = 2'b00;
        tick();
        check_irq("prio_set_wins_irq", 1'b1);
        tick();
        re = 1'b0;
        check_irq("prio_clear_irq", 1'b0);
        check("prio_clear_rd", rd, 32'h3);

        // Reset mid-run with state loaded and flag pending.
        gpi1 = '0;
        we1 = 1'b1; wd = 32'hFFFF_FFFF;
        tick();
        we1 = 1'b0;
        gpi2 = 32'h0000_0005;
        tick(); tick(); tick();
        check("mid_gpo1_loaded", gpo1, 32'hFFFF_FFFF);
        check_irq("mid_chg_irq", 1'b1);
        rst = 1'b1; we1 = 1'b1; wd = 32'h0000_0055; re = 1'b1; read_sel = 2'b00;
        gpi1 = 32'h1; gpi2 = '0;
        tick();
        rst = 1'b0; we1 = 1'b0; re = 1'b0;
        #1;
        check("mid_rst_gpo1", gpo1, 32'h0);
        check("mid_rst_gpo2", gpo2, 32'h0);
        check("mid_rst_rd", rd, 32'h0);
        check_irq("mid_rst_irq", 1'b0);
        tick();
        check_irq("rel_e1_irq", 1'b0);
        tick();
        check_irq("rel_e2_irq", 1'b0);
        check("rel_e2_rd", rd, 32'h1);
        tick();
        check_irq("rel_e3_irq", 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
